// File: rtl/axil_pkg.sv
// Shared constants and types for the AXI4-Lite SRAM responder.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_RESP = 3'd2,
    S_WR_DATA = 3'd3,
    S_WR_WAIT = 3'd4,
    S_WR_RESP = 3'd5
  } axil_resp_state_t;

  // Galois LFSR, taps 16,14,13,11, right-shifting form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/axil_sram_array.sv
// DEPTH x 32 word memory: byte-strobed synchronous write, asynchronous read.
module axil_sram_array #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_we,
  input  logic [3:0]       i_strb,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [31:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [31:0]      o_rdata
);

  logic [3:0][7:0] r_mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_strb[i]) r_mem[i_widx][i] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/axil_sram_resp.sv
// AXI4-Lite responder over a word SRAM with programmable R/B latency.
// Define AXIL_SRAM_RAND_DELAY_EN to add 0..7 LFSR-driven extra wait cycles.
module axil_sram_resp
  import axil_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter int                DEPTH  = 4096,
  parameter logic [ADDR_W-1:0] BASE   = 32'h8000_0000,
  parameter int                RD_LAT = 1,
  parameter int                WR_LAT = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_araddr,
  input  logic              i_arvalid,
  output logic              o_arready,
  output logic [31:0]       o_rdata,
  output logic [1:0]        o_rresp,
  output logic              o_rvalid,
  input  logic              i_rready,
  input  logic [ADDR_W-1:0] i_awaddr,
  input  logic              i_awvalid,
  output logic              o_awready,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  input  logic              i_wvalid,
  output logic              o_wready,
  output logic [1:0]        o_bresp,
  output logic              o_bvalid,
  input  logic              i_bready
);

  localparam int                IDX_W = $clog2(DEPTH);
  localparam int                CNT_W = 8;
  localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(4 * DEPTH);

  axil_resp_state_t   r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_wstrb;
  logic               r_axready;
  logic               r_wready;
  logic               r_rvalid;
  logic [31:0]        r_rdata;
  logic [1:0]         r_rresp;
  logic               r_bvalid;
  logic [1:0]         r_bresp;

  logic [ADDR_W-1:0]  w_off;
  logic               w_inr;
  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        w_mem_rdata;
  logic               w_we;
  logic [CNT_W-1:0]   w_extra;

  // Wraparound subtraction makes addresses below BASE land far above SPAN.
  assign w_off = r_addr - BASE;
  assign w_inr = (w_off < SPAN);
  assign w_idx = IDX_W'(w_off >> 2);
  assign w_we  = (r_state == S_WR_WAIT) && (r_cnt == '0) && w_inr;

`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_lfsr <= LFSR_SEED;
    else          r_lfsr <= lfsr_next(r_lfsr);
  end
  assign w_extra = CNT_W'(r_lfsr[2:0]);
`else
  assign w_extra = '0;
`endif

  axil_sram_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_mem (
    .i_clock (i_clock),
    .i_we    (w_we),
    .i_strb  (r_wstrb),
    .i_widx  (w_idx),
    .i_wdata (r_wdata),
    .i_ridx  (w_idx),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_axready <= 1'b1;
      r_wready  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Read wins a tie; AW stays pending until the next IDLE.
          if (i_arvalid) begin
            r_addr    <= i_araddr;
            r_axready <= 1'b0;
            r_cnt     <= CNT_W'(RD_LAT) + w_extra;
            r_state   <= S_RD_WAIT;
          end else if (i_awvalid) begin
            r_addr    <= i_awaddr;
            r_axready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= S_WR_DATA;
          end
        end
        S_RD_WAIT: begin
          if (r_cnt == '0) begin
            r_rdata  <= w_inr ? w_mem_rdata : 32'h0;
            r_rresp  <= w_inr ? RESP_OKAY : RESP_SLVERR;
            r_rvalid <= 1'b1;
            r_state  <= S_RD_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RD_RESP: begin
          if (i_rready) begin
            r_rvalid  <= 1'b0;
            r_axready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_WR_DATA: begin
          if (i_wvalid) begin
            r_wready <= 1'b0;
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
            r_cnt    <= CNT_W'(WR_LAT) + w_extra;
            r_state  <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (r_cnt == '0) begin
            r_bresp  <= w_inr ? RESP_OKAY : RESP_SLVERR;
            r_bvalid <= 1'b1;
            r_state  <= S_WR_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_RESP: begin
          if (i_bready) begin
            r_bvalid  <= 1'b0;
            r_axready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_arready = r_axready;
  assign o_awready = r_axready;
  assign o_wready  = r_wready;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;

endmodule

// File: tb/tb_axil_sram_resp.sv
// Directed bench for axil_sram_resp with default latencies (RD_LAT=WR_LAT=1).
module tb_axil_sram_resp;

  localparam int RD_LAT = 1;
  localparam int WR_LAT = 1;
  localparam int TMO    = 100;

  logic        clk, rst_n;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, awvalid, wvalid, rready, bready;
  logic [3:0]  wstrb;
  logic        arready, awready, wready, rvalid, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;

  int n_tests = 0;
  int n_fail  = 0;

  axil_sram_resp #(
    .ADDR_W(32), .DEPTH(4096), .BASE(32'h8000_0000), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
  ) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_araddr(araddr), .i_arvalid(arvalid), .o_arready(arready),
    .o_rdata(rdata), .o_rresp(rresp), .o_rvalid(rvalid), .i_rready(rready),
    .i_awaddr(awaddr), .i_awvalid(awvalid), .o_awready(awready),
    .i_wdata(wdata), .i_wstrb(wstrb), .i_wvalid(wvalid), .o_wready(wready),
    .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_for(input string nm, ref logic sig, output int cyc);
    cyc = 0;
    while (sig !== 1'b1 && cyc < TMO) begin tick(); cyc++; end
    if (sig !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: signal not seen in %0d cycles", nm, TMO);
    end
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int hold, output logic [1:0] resp, output int lat,
                           output bit stable);
    int c;
    awaddr = a; awvalid = 1'b1;
    wait_for("aw", awready, c);
    tick(); awvalid = 1'b0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    wait_for("w", wready, c);
    tick(); wvalid = 1'b0;
    wait_for("b", bvalid, lat);
    resp = bresp; stable = 1'b1;
    repeat (hold) begin
      tick();
      if (bvalid !== 1'b1 || bresp !== resp || awready !== 1'b0) stable = 1'b0;
    end
    bready = 1'b1; tick(); bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] resp, output int lat, output bit stable);
    int c;
    araddr = a; arvalid = 1'b1;
    wait_for("ar", arready, c);
    tick(); arvalid = 1'b0;
    wait_for("r", rvalid, lat);
    d = rdata; resp = rresp; stable = 1'b1;
    repeat (hold) begin
      tick();
      if (rvalid !== 1'b1 || rdata !== d || rresp !== resp || arready !== 1'b0) stable = 1'b0;
    end
    rready = 1'b1; tick(); rready = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b11000) begin
      n_fail++; $display("FAIL reset_hs: got %b want 11000", {arready, awready, wready, rvalid, bvalid});
    end
    n_tests++;
    if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_tests++;
    if ({rresp, bresp} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_resp: got %b want 0000", {rresp, bresp});
    end
  endtask

  task automatic test_write_read();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    axi_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, r, lat, st);
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL wr_bresp: got %b want 00", r); end
    n_tests++;
    if (lat != 1 + WR_LAT) begin n_fail++; $display("FAIL wr_lat: got %0d want %0d", lat, 1 + WR_LAT); end
    axi_read(32'h8000_0010, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) begin
      n_fail++; $display("FAIL rd_back: got %h/%b want deadbeef/00", d, r);
    end
    n_tests++;
    if (lat != 1 + RD_LAT) begin n_fail++; $display("FAIL rd_lat: got %0d want %0d", lat, 1 + RD_LAT); end
    // Byte offset in the address is ignored
    axi_read(32'h8000_0013, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_unaligned: got %h want deadbeef", d); end
  endtask

  task automatic test_strobes();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    axi_write(32'h8000_0020, 32'h11223344, 4'hF, 0, r, lat, st);
    axi_write(32'h8000_0020, 32'h000000AA, 4'b0001, 0, r, lat, st);
    axi_read(32'h8000_0020, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h112233AA) begin n_fail++; $display("FAIL strb_0001: got %h want 112233aa", d); end
    axi_write(32'h8000_0020, 32'h0000BBCC, 4'b0011, 0, r, lat, st);
    axi_read(32'h8000_0020, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h1122BBCC) begin n_fail++; $display("FAIL strb_0011: got %h want 1122bbcc", d); end
    axi_write(32'h8000_0020, 32'hFFFFFFFF, 4'b0000, 0, r, lat, st);
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL strb_0000_resp: got %b want 00", r); end
    axi_read(32'h8000_0020, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h1122BBCC) begin n_fail++; $display("FAIL strb_0000_data: got %h want 1122bbcc", d); end
    axi_write(32'h8000_0024, 32'h12345678, 4'b1100, 0, r, lat, st);
    axi_read(32'h8000_0024, 0, d, r, lat, st);
    n_tests++;
    if (d[31:16] !== 16'h1234) begin n_fail++; $display("FAIL strb_1100: got %h want 1234xxxx", d); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    axi_write(32'h8000_0000, 32'h55AA55AA, 4'hF, 0, r, lat, st);
    axi_write(32'h8000_3FFC, 32'h0BADF00D, 4'hF, 0, r, lat, st);
    n_tests++;
    if (r !== 2'b00) begin n_fail++; $display("FAIL oor_last_wr: got %b want 00", r); end
    axi_write(32'h8000_4000, 32'hFFFFFFFF, 4'hF, 0, r, lat, st);
    n_tests++;
    if (r !== 2'b10) begin n_fail++; $display("FAIL oor_wr_resp: got %b want 10", r); end
    axi_read(32'h8000_0000, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h55AA55AA) begin n_fail++; $display("FAIL oor_word0: got %h want 55aa55aa", d); end
    axi_read(32'h8000_3FFC, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h0BADF00D || r !== 2'b00) begin
      n_fail++; $display("FAIL oor_last_rd: got %h/%b want 0badf00d/00", d, r);
    end
    axi_read(32'h7FFF_FFFC, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h0 || r !== 2'b10) begin
      n_fail++; $display("FAIL oor_below: got %h/%b want 00000000/10", d, r);
    end
    axi_read(32'h8000_4000, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h0 || r !== 2'b10) begin
      n_fail++; $display("FAIL oor_above: got %h/%b want 00000000/10", d, r);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] r; logic [31:0] d; int lat; bit st;
    axi_read(32'h8000_0010, 5, d, r, lat, st);
    n_tests++;
    if (!st || d !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bp_read: stable=%0d data=%h want 1/deadbeef", st, d);
    end
    axi_write(32'h8000_0028, 32'hA5A5A5A5, 4'hF, 5, r, lat, st);
    n_tests++;
    if (!st || r !== 2'b00) begin
      n_fail++; $display("FAIL bp_write: stable=%0d resp=%b want 1/00", st, r);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] r; logic [31:0] d; int lat, c; bit st;
    araddr = 32'h8000_0010; arvalid = 1'b1;
    awaddr = 32'h8000_0030; awvalid = 1'b1;
    wdata = 32'hCAFEF00D; wstrb = 4'hF;
    tick(); arvalid = 1'b0;
    n_tests++;
    if (awready !== 1'b0) begin n_fail++; $display("FAIL sim_aw_blocked: got %b want 0", awready); end
    wait_for("sim_r", rvalid, c);
    n_tests++;
    if (rdata !== 32'hDEADBEEF || awready !== 1'b0) begin
      n_fail++; $display("FAIL sim_read_first: got %h/aw=%b want deadbeef/0", rdata, awready);
    end
    rready = 1'b1; tick(); rready = 1'b0;
    n_tests++;
    if (awready !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++; $display("FAIL sim_after_r: aw=%b rv=%b want 1/0", awready, rvalid);
    end
    tick(); awvalid = 1'b0;
    n_tests++;
    if (wready !== 1'b1) begin n_fail++; $display("FAIL sim_wready: got %b want 1", wready); end
    wvalid = 1'b1; tick(); wvalid = 1'b0;
    wait_for("sim_b", bvalid, c);
    n_tests++;
    if (bresp !== 2'b00) begin n_fail++; $display("FAIL sim_bresp: got %b want 00", bresp); end
    bready = 1'b1; tick(); bready = 1'b0;
    axi_read(32'h8000_0030, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'hCAFEF00D) begin n_fail++; $display("FAIL sim_wr_data: got %h want cafef00d", d); end
  endtask

  task automatic test_async_reset();
    logic [1:0] r; logic [31:0] d; int lat, c; bit st;
    axi_write(32'h8000_0040, 32'h12345678, 4'hF, 0, r, lat, st);
    awaddr = 32'h8000_0040; awvalid = 1'b1;
    wait_for("ar_aw", awready, c);
    tick(); awvalid = 1'b0;
    wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1'b1;
    wait_for("ar_w", wready, c);
    tick(); wvalid = 1'b0;
    // Now in WR_WAIT; drop reset between edges
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({arready, awready, wready, bvalid} !== 4'b1100) begin
      n_fail++; $display("FAIL async_rst: got %b want 1100", {arready, awready, wready, bvalid});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    axi_read(32'h8000_0040, 0, d, r, lat, st);
    n_tests++;
    if (d !== 32'h12345678 || r !== 2'b00) begin
      n_fail++; $display("FAIL async_rst_mem: got %h/%b want 12345678/00", d, r);
    end
    n_tests++;
    if (lat != 1 + RD_LAT) begin n_fail++; $display("FAIL async_rst_lat: got %0d want %0d", lat, 1 + RD_LAT); end
  endtask

  initial begin
    rst_n = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    #12;
    test_reset();
    tick(); rst_n = 1'b1; tick();
    test_write_read();
    test_strobes();
    test_out_of_range();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_sram_resp.md
Name: axil_sram_resp

Overview:
- AXI4-Lite responder (slave) backed by a word-addressed on-chip SRAM model.
- Serves the load/store unit's AR/R and AW/W/B channels, one transaction at a time.
- Adds a programmable response latency so the core's handshake logic runs under non-zero memory delay.

Parameters:
- ADDR_W, 32, address width.
- DEPTH, 4096, number of 32-bit words; valid byte range is BASE .. BASE+4*DEPTH-1.
- BASE, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR accept to rvalid (0 = next cycle).
- WR_LAT, 1, cycles from W accept to bvalid (0 = next cycle).

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response: 00 OKAY, 10 SLVERR.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte lane enables.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response: 00 OKAY, 10 SLVERR.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - arready=1, awready=1, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - Latency counter cleared.
  - SRAM contents are not reset.
  - Any in-flight transaction is dropped with no response; a partial write is not committed.
- States: IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP.
- IDLE:
  - arready=awready=1.
  - arvalid: latch araddr; arready and awready go 0; counter=RD_LAT; go to RD_WAIT.
  - awvalid alone: latch awaddr; arready and awready go 0; wready goes 1; go to WR_DATA.
  - arvalid and awvalid together: read wins; AW is left unaccepted and is taken on the next return to IDLE.
- RD_WAIT:
  - Counter decrements each cycle.
  - At 0: rdata=mem[index], rresp=00, rvalid=1; go to RD_RESP.
  - index = (addr-BASE)>>2. addr[1:0] is ignored; the full word is returned and byte/half extraction is the initiator's job.
  - Out of range: rdata=0, rresp=10.
- RD_RESP:
  - Hold rvalid, rdata and rresp stable until rready.
  - On rvalid&&rready: rvalid=0, arready=awready=1; go to IDLE.
- WR_DATA:
  - On wvalid: wready=0; latch wdata and wstrb; counter=WR_LAT; go to WR_WAIT.
- WR_WAIT:
  - At counter 0: for each i with wstrb[i], write mem[index] byte i = wdata byte i.
  - Out of range: no write, bresp=10; otherwise bresp=00.
  - bvalid=1; go to WR_RESP.
  - wstrb=0000 is OKAY and performs no write.
- WR_RESP:
  - Hold bvalid and bresp until bready.
  - On handshake: bvalid=0, arready=awready=1; go to IDLE.
- Minimum read: AR handshake at cycle t, rvalid at t+1+RD_LAT.
- Minimum write: W handshake at cycle t, bvalid at t+1+WR_LAT.
- No outstanding-transaction overlap: a new AR/AW is never accepted while R or B is pending.
- Range check is done on the full address using subtraction; addresses below BASE count as out of range.

Optional Feature:
- Macro: AXIL_SRAM_RAND_DELAY_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - On entry to RD_WAIT or WR_WAIT, the counter is loaded with the base latency plus lfsr[2:0], i.e. 0..7 extra cycles.
- Undefined: latency is exactly RD_LAT / WR_LAT and no LFSR logic exists.

Decomposition:
- Shared package axil_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - State enum type axil_resp_state_t.
  - LFSR seed and tap constants.
- One natural sub-module, axil_sram_array: the DEPTH x 32 memory with a byte-strobed synchronous write port and an asynchronous read port.

Test Plan:
- Write/read back:
  - Write awaddr=8000_0010, wdata=DEADBEEF, wstrb=1111; then read 8000_0010.
  - Expect bresp=00, rdata=DEADBEEF, rresp=00, rvalid exactly 1+RD_LAT cycles after the AR handshake.
- Byte strobes:
  - Preload 8000_0020=11223344; write wdata=000000AA, wstrb=0001.
  - Read returns 112233AA; a following wstrb=0011 write of 0000BBCC gives 1122BBCC.
- Out of range:
  - Write to 8000_0000+4*DEPTH: expect bresp=10 and memory unchanged.
  - Read 7FFF_FFFC: expect rresp=10, rdata=0.
- Backpressure:
  - Hold rready=0 for 5 cycles after rvalid: rvalid/rdata stay stable and arready stays 0.
  - Same check with bready=0 for the write response.
- Simultaneous request:
  - arvalid and awvalid high in the same IDLE cycle: read completes first.
  - awready asserts only after the R handshake; the write then completes correctly.
- Async reset mid-write:
  - Drop reset in WR_WAIT: outputs reach reset values without a clock edge.
  - Target word is unchanged afterwards; the next transaction completes normally.
